// File: rtl/led_ctrl_pkg.sv
// Shared switch-field layout and mode encodings for the LED controller.
// The pattern engine imports the same definitions.
package led_ctrl_pkg;

    localparam int SWITCH_WIDTH = 4;

    localparam int MODE_LSB  = 0;
    localparam int MODE_MSB  = 1;
    localparam int SPEED_BIT = 2;
    localparam int DIR_BIT   = 3;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'b00,
        MODE_COUNT  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a persistence counter.
// load flags the edge on which clean takes the synchronised value.
module switch_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic Mhz100Clock,
    input  logic ResetN,
    input  logic raw,
    output logic clean,
    output logic load
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    assign load = (sync2 != clean) && (cnt == CNT_LAST);

    always_ff @(posedge Mhz100Clock or negedge ResetN) begin
        if (!ResetN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            clean <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the accepted level throws away the partial count.
            if (sync2 == clean) begin
                cnt <= '0;
            end else if (load) begin
                clean <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// Switch front end: debounced switch bus, mode-change pulse and a step
// strobe whose period follows the speed switch.
module switch_conditioner
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SLOW_PERIOD     = 50_000_000,
    parameter int FAST_PERIOD     = 25_000_000
) (
    input  logic                    Mhz100Clock,
    input  logic                    ResetN,
    input  logic [SWITCH_WIDTH-1:0] SwitchRaw,
    output logic [SWITCH_WIDTH-1:0] SwitchClean,
    output logic                    ModeChange,
    output logic                    Tick
);

    localparam int TW = $clog2(SLOW_PERIOD);
    localparam logic [TW-1:0] SLOW_LAST = TW'(SLOW_PERIOD - 1);
    localparam logic [TW-1:0] FAST_LAST = TW'(FAST_PERIOD - 1);
    // Direction only steers the pattern; it never restarts the step timer.
    localparam logic [SWITCH_WIDTH-1:0] RESTART_MASK = ~(SWITCH_WIDTH'(1) << DIR_BIT);

    logic [SWITCH_WIDTH-1:0] load;
    logic                    mode_upd_p0;
    logic                    mode_upd_p1;
    logic                    restart;
    logic [TW-1:0]           tick_cnt;
    logic [TW-1:0]           tick_last;

    for (genvar i = 0; i < SWITCH_WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .Mhz100Clock(Mhz100Clock),
            .ResetN     (ResetN),
            .raw        (SwitchRaw[i]),
            .clean      (SwitchClean[i]),
            .load       (load[i])
        );
    end

    assign mode_upd_p0 = |load[MODE_MSB:MODE_LSB];
    assign restart     = |(load & RESTART_MASK);
    assign tick_last   = SwitchClean[SPEED_BIT] ? FAST_LAST : SLOW_LAST;

    // p0 -> p1: mode update seen on the clean edge, pulse one edge later
    always_ff @(posedge Mhz100Clock or negedge ResetN) begin
        if (!ResetN) begin
            mode_upd_p1 <= 1'b0;
            ModeChange  <= 1'b0;
        end else begin
            mode_upd_p1 <= mode_upd_p0;
            ModeChange  <= mode_upd_p1;
        end
    end

    // Restart has priority so a stale count from the slow period never fires.
    always_ff @(posedge Mhz100Clock or negedge ResetN) begin
        if (!ResetN) begin
            tick_cnt <= '0;
            Tick     <= 1'b0;
        end else if (restart) begin
            tick_cnt <= '0;
            Tick     <= 1'b0;
        end else if (tick_cnt == tick_last) begin
            tick_cnt <= '0;
            Tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
            Tick     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with short debounce and tick periods.
module tb_switch_conditioner;

    logic       Mhz100Clock;
    logic       ResetN;
    logic [3:0] SwitchRaw;
    logic [3:0] SwitchClean;
    logic       ModeChange;
    logic       Tick;

    int checks = 0;
    int errors = 0;

    switch_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SLOW_PERIOD    (10),
        .FAST_PERIOD    (5)
    ) dut (
        .Mhz100Clock(Mhz100Clock),
        .ResetN     (ResetN),
        .SwitchRaw  (SwitchRaw),
        .SwitchClean(SwitchClean),
        .ModeChange (ModeChange),
        .Tick       (Tick)
    );

    initial Mhz100Clock = 1'b0;
    always #5 Mhz100Clock = ~Mhz100Clock;

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge Mhz100Clock);
        #1;
    endtask

    // Reset with switches low, release just after an edge, then drive raw.
    task automatic apply_reset(input logic [3:0] raw_after);
        SwitchRaw = 4'b0000;
        ResetN    = 1'b0;
        cyc();
        cyc();
        ResetN    = 1'b1;
        SwitchRaw = raw_after;
    endtask

    task automatic test_reset();
        SwitchRaw = 4'b0000;
        ResetN    = 1'b0;
        #1;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if ({SwitchClean, ModeChange, Tick} !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold n=%0d got clean=%b mc=%b tick=%b want all 0", n, SwitchClean, ModeChange, Tick);
            end
            cyc();
        end
        ResetN = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            checks++;
            if (SwitchClean !== 4'b0000) begin
                errors++;
                $display("FAIL reset_clean n=%0d got %b want 0000", n, SwitchClean);
            end
            checks++;
            if (ModeChange !== 1'b0) begin
                errors++;
                $display("FAIL reset_mc n=%0d got %b want 0", n, ModeChange);
            end
            checks++;
            if (Tick !== (n % 10 == 0)) begin
                errors++;
                $display("FAIL reset_tick n=%0d got %b want %b", n, Tick, (n % 10 == 0));
            end
        end
    endtask

    task automatic test_mode_change();
        apply_reset(4'b0001);
        for (int n = 1; n <= 20; n++) begin
            cyc();
            checks++;
            if (SwitchClean !== ((n >= 6) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL mode_clean n=%0d got %b", n, SwitchClean);
            end
            checks++;
            if (ModeChange !== (n == 7)) begin
                errors++;
                $display("FAIL mode_mc n=%0d got %b want %b", n, ModeChange, (n == 7));
            end
            checks++;
            if (Tick !== (n == 16)) begin
                errors++;
                $display("FAIL mode_tick n=%0d got %b want %b", n, Tick, (n == 16));
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset(4'b0001);
        for (int n = 1; n <= 15; n++) begin
            cyc();
            if (n == 3) SwitchRaw = 4'b0000;
            checks++;
            if (SwitchClean !== 4'b0000) begin
                errors++;
                $display("FAIL glitch_clean n=%0d got %b want 0000", n, SwitchClean);
            end
            checks++;
            if (ModeChange !== 1'b0) begin
                errors++;
                $display("FAIL glitch_mc n=%0d got %b want 0", n, ModeChange);
            end
            checks++;
            if (Tick !== (n == 10)) begin
                errors++;
                $display("FAIL glitch_tick n=%0d got %b want %b", n, Tick, (n == 10));
            end
        end
    endtask

    task automatic test_speed();
        logic [3:0] exp_clean;
        logic       exp_tick;
        apply_reset(4'b0100);
        for (int n = 1; n <= 55; n++) begin
            cyc();
            if (n == 27) SwitchRaw = 4'b0000;
            exp_clean = (n >= 6 && n < 33) ? 4'b0100 : 4'b0000;
            exp_tick  = (n == 11 || n == 16 || n == 21 || n == 26 || n == 31 ||
                         n == 43 || n == 53);
            checks++;
            if (SwitchClean !== exp_clean) begin
                errors++;
                $display("FAIL speed_clean n=%0d got %b want %b", n, SwitchClean, exp_clean);
            end
            checks++;
            if (ModeChange !== 1'b0) begin
                errors++;
                $display("FAIL speed_mc n=%0d got %b want 0", n, ModeChange);
            end
            checks++;
            if (Tick !== exp_tick) begin
                errors++;
                $display("FAIL speed_tick n=%0d got %b want %b", n, Tick, exp_tick);
            end
        end
    endtask

    task automatic test_restart_coincide();
        apply_reset(4'b0000);
        for (int n = 1; n <= 21; n++) begin
            cyc();
            if (n == 4) SwitchRaw = 4'b0100;
            checks++;
            if (SwitchClean !== ((n >= 10) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL coincide_clean n=%0d got %b", n, SwitchClean);
            end
            checks++;
            if (Tick !== (n == 15 || n == 20)) begin
                errors++;
                $display("FAIL coincide_tick n=%0d got %b want %b", n, Tick, (n == 15 || n == 20));
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(4'b0000);
        cyc();
        cyc();
        cyc();
        SwitchRaw = 4'b1000;
        for (int n = 4; n <= 7; n++) cyc();
        checks++;
        if (SwitchClean !== 4'b0000) begin
            errors++;
            $display("FAIL mid_pre_clean got %b want 0000", SwitchClean);
        end
        ResetN = 1'b0;
        #1;
        checks++;
        if ({SwitchClean, ModeChange, Tick} !== 6'b0) begin
            errors++;
            $display("FAIL mid_async got clean=%b mc=%b tick=%b want all 0", SwitchClean, ModeChange, Tick);
        end
        cyc();
        cyc();
        checks++;
        if ({SwitchClean, ModeChange, Tick} !== 6'b0) begin
            errors++;
            $display("FAIL mid_hold got clean=%b mc=%b tick=%b want all 0", SwitchClean, ModeChange, Tick);
        end
        ResetN = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            cyc();
            checks++;
            if (SwitchClean !== ((n >= 6) ? 4'b1000 : 4'b0000)) begin
                errors++;
                $display("FAIL mid_clean n=%0d got %b", n, SwitchClean);
            end
            checks++;
            if (ModeChange !== 1'b0) begin
                errors++;
                $display("FAIL mid_mc n=%0d got %b want 0", n, ModeChange);
            end
            checks++;
            if (Tick !== (n == 10 || n == 20)) begin
                errors++;
                $display("FAIL mid_tick n=%0d got %b want %b", n, Tick, (n == 10 || n == 20));
            end
        end
    endtask

    initial begin
        ResetN    = 1'b0;
        SwitchRaw = 4'b0000;
        cyc();
        test_reset();
        test_mode_change();
        test_glitch();
        test_speed();
        test_restart_coincide();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Front-end stage between the board slide switches and the LED pattern engine. Synchronises and debounces the four raw switch inputs and presents a clean switch bus. Generates a one-cycle ModeChange pulse when the mode field changes and a free-running Tick strobe whose period is set by the speed switch. The pattern engine consumes these outputs instead of sampling raw switches and dividing the clock itself.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronised bit must differ from its clean value before it is accepted (10 ms at 100 MHz); legal ≥1.
- SLOW_PERIOD, 50_000_000: Tick period in cycles when SwitchClean[2]=0; legal ≥FAST_PERIOD.
- FAST_PERIOD, 25_000_000: Tick period in cycles when SwitchClean[2]=1; legal ≥2.

Ports:
- Mhz100Clock  in  1  sole clock, 100 MHz; all state on its rising edge.
- ResetN  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to Mhz100Clock upstream of this block.
- SwitchRaw  in  4  raw asynchronous switches: [1:0] mode, [2] speed, [3] direction.
- SwitchClean  out  4  debounced switches, registered.
- ModeChange  out  1  one-cycle pulse after SwitchClean[1:0] changes.
- Tick  out  1  one-cycle step strobe for the pattern engine.

## Operation
- Reset (ResetN=0): sync flops, SwitchClean, debounce counters, tick counter, ModeChange and Tick all go to 0 immediately and hold until release.
- Synchroniser: two flops per bit (sync1, sync2). Only sync2 feeds the debouncer.
- Debounce, per bit and independent:
  - sync2 == clean: counter cleared to 0.
  - sync2 != clean, counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync2 != clean, counter == DEBOUNCE_CYCLES-1: clean takes sync2, counter cleared.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never reaches SwitchClean.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- ModeChange: registered and high for exactly one cycle in the cycle after any SwitchClean[1:0] update. SwitchClean[3:2] never raises it.
- Tick counter:
  - Width $clog2(SLOW_PERIOD).
  - Period P = FAST_PERIOD if SwitchClean[2] else SLOW_PERIOD.
  - Counter runs 0..P-1. Tick=1 in the cycle after the counter equals P-1; the counter then wraps to 0.
- Restart: any change of SwitchClean[2:0] clears the tick counter to 0 in the same edge, and no Tick is issued for that edge.
  - Restart wins over a coincident terminal count.
  - If the counter is ≥P after a slow-to-fast switch, the restart clears it. There is no out-of-range state.
- SwitchClean[3] changes affect neither the tick counter nor ModeChange.
- After reset, switches already held high appear on SwitchClean after the debounce latency. A held mode ≠00 therefore produces one ModeChange.

## Timing
- Raw to clean latency: SwitchRaw stable from edge k gives sync2 at edge k+1. SwitchClean updates at edge k+1+DEBOUNCE_CYCLES.
- ModeChange asserts one edge after the SwitchClean[1:0] update and lasts one cycle.
- After reset release or restart, the first Tick asserts P edges later; subsequent Ticks every P cycles.
- Mid-operation reset clears all state asynchronously, including any partially elapsed debounce or tick count.

## Structure
- Shared package led_ctrl_pkg:
  - SWITCH_WIDTH=4.
  - Field indices MODE_LSB=0, MODE_MSB=1, SPEED_BIT=2, DIR_BIT=3.
  - Mode encodings MODE_BLINK=2'b00, MODE_COUNT=2'b01, MODE_BOUNCE=2'b10, MODE_FILL=2'b11.
  - The pattern engine uses the same package.
- Sub-module switch_debounce_bit: synchroniser plus debounce counter for one bit, parameter DEBOUNCE_CYCLES. Instantiated SWITCH_WIDTH times. Tick and ModeChange logic stays in the top module.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, SLOW_PERIOD=10, FAST_PERIOD=5.
- Reset with SwitchRaw=0000 held 40 cycles:
  - SwitchClean=0000 and ModeChange never asserts.
  - Tick at cycles 10, 20, 30 after release.
- SwitchRaw 0000→0001 at edge k, held:
  - SwitchClean=0001 at k+5; ModeChange=1 at k+6 only.
  - Tick counter restarts, next Tick at k+15.
- SwitchRaw[0] pulsed high for 3 cycles, then low: SwitchClean stays 0000 and ModeChange stays 0.
- SwitchRaw[2] 0→1 held: after SwitchClean[2] rises, Ticks every 5 cycles with no ModeChange. Returning to 0 restores 10-cycle spacing from the new restart.
- SwitchRaw[2] change timed so the clean update coincides with counter=9: no Tick that cycle, and the next Tick arrives 5 cycles later.
- ResetN pulled low mid-debounce (counter=2) with Tick counter=7: all outputs 0 immediately. After release, the full 5-cycle debounce is required again and the first Tick is 10 cycles after release.
